// File: rtl/timestamp_ms.sv
// Millisecond timestamp counter with a snapshot serializer.
// The live count advances on each cycle tmr_1khz is high. A snap_req taken
// in IDLE freezes the count into a shadow register, which is then streamed
// MSB-first, one byte per valid/ready beat. All outputs come from registers.
module timestamp_ms #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tmr_1khz,
    input  logic             clr,
    input  logic             snap_req,
    output logic [WIDTH-1:0] ts,
    output logic             wrap,
    output logic             busy,
    output logic             snap_drop,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready
);

    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] ts_r;
    logic             wrap_r;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_nx_s;
    logic [IW-1:0]    idx_r;
    logic [IW-1:0]    idx_nx_s;
    logic             drop_r;
    logic             drop_nx_s;
    logic             busy_r;
    logic             busy_nx_s;
    logic [7:0]       data_r;
    logic [7:0]       data_nx_s;
    logic             valid_r;
    logic             valid_nx_s;
    logic             last_r;
    logic             last_nx_s;
    logic             beat_s;

    // Byte i of v counted from the MSB end (i = 0 is the top byte).
    function automatic logic [7:0] byte_at(input logic [WIDTH-1:0] v,
                                           input logic [IW-1:0]    i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (IW'(k) == i) begin
                b = v[WIDTH-1-8*k -: 8];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    assign beat_s = valid_r & tx_ready;

    // Live millisecond count and sticky wrap flag; clr takes priority over a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r   <= '0;
            wrap_r <= 1'b0;
        end else if (clr) begin
            ts_r   <= '0;
            wrap_r <= 1'b0;
        end else if (tmr_1khz) begin
            ts_r   <= ts_r + WIDTH'(1);
            wrap_r <= (&ts_r) ? 1'b1 : wrap_r;
        end else begin
            ts_r   <= ts_r;
            wrap_r <= wrap_r;
        end
    end

    // Next-state and next-output logic of the snapshot serializer.
    always_comb begin
        state_nx_s  = state_r;
        shadow_nx_s = shadow_r;
        idx_nx_s    = idx_r;
        drop_nx_s   = drop_r;
        busy_nx_s   = busy_r;
        data_nx_s   = data_r;
        valid_nx_s  = valid_r;
        last_nx_s   = last_r;
        case (state_r)
            IDLE: begin
                if (snap_req) begin
                    // Shadow takes the count before any same-cycle tick.
                    shadow_nx_s = ts_r;
                    idx_nx_s    = '0;
                    drop_nx_s   = 1'b0;
                    state_nx_s  = SEND;
                    busy_nx_s   = 1'b1;
                    valid_nx_s  = 1'b1;
                    data_nx_s   = ts_r[WIDTH-1 -: 8];
                    last_nx_s   = (NB == 1) ? 1'b1 : 1'b0;
                end else begin
                    busy_nx_s  = 1'b0;
                    valid_nx_s = 1'b0;
                    last_nx_s  = 1'b0;
                end
            end
            SEND: begin
                // Any request while a frame is in flight, including the
                // final-beat cycle, is dropped and remembered.
                if (snap_req) begin
                    drop_nx_s = 1'b1;
                end else begin
                    drop_nx_s = drop_r;
                end
                if (beat_s) begin
                    if (idx_r == IW'(NB - 1)) begin
                        state_nx_s = IDLE;
                        busy_nx_s  = 1'b0;
                        valid_nx_s = 1'b0;
                        last_nx_s  = 1'b0;
                        data_nx_s  = 8'h00;
                    end else begin
                        idx_nx_s  = idx_r + IW'(1);
                        data_nx_s = byte_at(shadow_r, idx_r + IW'(1));
                        last_nx_s = ((idx_r + IW'(1)) == IW'(NB - 1)) ? 1'b1 : 1'b0;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
                busy_nx_s  = 1'b0;
                valid_nx_s = 1'b0;
                last_nx_s  = 1'b0;
                data_nx_s  = 8'h00;
            end
        endcase
    end

    // Serializer state and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            shadow_r <= '0;
            idx_r    <= '0;
            drop_r   <= 1'b0;
            busy_r   <= 1'b0;
            data_r   <= 8'h00;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            shadow_r <= shadow_nx_s;
            idx_r    <= idx_nx_s;
            drop_r   <= drop_nx_s;
            busy_r   <= busy_nx_s;
            data_r   <= data_nx_s;
            valid_r  <= valid_nx_s;
            last_r   <= last_nx_s;
        end
    end

    assign ts        = ts_r;
    assign wrap      = wrap_r;
    assign busy      = busy_r;
    assign snap_drop = drop_r;
    assign tx_data   = data_r;
    assign tx_valid  = valid_r;
    assign tx_last   = last_r;

endmodule

// File: tb/tb_timestamp_ms.sv
// Bench for timestamp_ms: three instances (WIDTH 8, 16, 32) share stimulus and
// are checked every cycle against a byte-queue reference model.
module tb_timestamp_ms;

    logic clk = 1'b0;
    logic rst;
    logic tmr_1khz;
    logic clr;
    logic snap_req;
    logic tx_ready;

    logic [7:0]  ts8;
    logic [15:0] ts16;
    logic [31:0] ts32;
    logic        wrap_o [3];
    logic        busy_o [3];
    logic        drop_o [3];
    logic        txv_o  [3];
    logic        txl_o  [3];
    logic [7:0]  txd_o  [3];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: live count, flags, and the bytes still owed downstream.
    longint unsigned m_ts   [3];
    bit              m_wrap [3];
    bit              m_drop [3];
    logic [7:0]      q0 [$];
    logic [7:0]      q1 [$];
    logic [7:0]      q2 [$];

    always #10 clk = ~clk;

    timestamp_ms #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .tmr_1khz(tmr_1khz), .clr(clr), .snap_req(snap_req),
        .ts(ts8), .wrap(wrap_o[0]), .busy(busy_o[0]), .snap_drop(drop_o[0]),
        .tx_data(txd_o[0]), .tx_valid(txv_o[0]), .tx_last(txl_o[0]), .tx_ready(tx_ready)
    );
    timestamp_ms #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .tmr_1khz(tmr_1khz), .clr(clr), .snap_req(snap_req),
        .ts(ts16), .wrap(wrap_o[1]), .busy(busy_o[1]), .snap_drop(drop_o[1]),
        .tx_data(txd_o[1]), .tx_valid(txv_o[1]), .tx_last(txl_o[1]), .tx_ready(tx_ready)
    );
    timestamp_ms #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .tmr_1khz(tmr_1khz), .clr(clr), .snap_req(snap_req),
        .ts(ts32), .wrap(wrap_o[2]), .busy(busy_o[2]), .snap_drop(drop_o[2]),
        .tx_data(txd_o[2]), .tx_valid(txv_o[2]), .tx_last(txl_o[2]), .tx_ready(tx_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int nb_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [63:0] ts_of(input int k);
        case (k)
            0:       return {56'd0, ts8};
            1:       return {48'd0, ts16};
            default: return {32'd0, ts32};
        endcase
    endfunction

    function automatic int qsz(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int k, input logic [7:0] b);
        case (k)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    // Advance the model by one clock edge with the given sampled inputs.
    task automatic model_step(input logic t, input logic c, input logic s, input logic r);
        for (int k = 0; k < 3; k++) begin
            int sz;
            longint unsigned mask;
            sz   = qsz(k);
            mask = (64'd1 << (8 * nb_of(k))) - 64'd1;
            if (s) begin
                if (sz > 0) begin
                    m_drop[k] = 1'b1;
                end else begin
                    m_drop[k] = 1'b0;
                    for (int i = nb_of(k) - 1; i >= 0; i--) begin
                        qpush(k, 8'((m_ts[k] >> (8 * i)) & 64'hff));
                    end
                end
            end
            if (sz > 0 && r) qpop(k);
            if (c) begin
                m_ts[k]   = 0;
                m_wrap[k] = 1'b0;
            end else if (t) begin
                if (m_ts[k] == mask) m_wrap[k] = 1'b1;
                m_ts[k] = (m_ts[k] + 1) & mask;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("ts_i%0d", k), ts_of(k), m_ts[k]);
            check_eq($sformatf("wrap_i%0d", k), {63'd0, wrap_o[k]}, {63'd0, m_wrap[k]});
            check_eq($sformatf("drop_i%0d", k), {63'd0, drop_o[k]}, {63'd0, m_drop[k]});
            check_eq($sformatf("busy_i%0d", k), {63'd0, busy_o[k]}, {63'd0, (qsz(k) > 0)});
            check_eq($sformatf("valid_i%0d", k), {63'd0, txv_o[k]}, {63'd0, (qsz(k) > 0)});
            check_eq($sformatf("last_i%0d", k), {63'd0, txl_o[k]}, {63'd0, (qsz(k) == 1)});
            if (qsz(k) > 0) begin
                check_eq($sformatf("data_i%0d", k), {56'd0, txd_o[k]}, {56'd0, qfront(k)});
            end
        end
    endtask

    // Called at a falling edge: drive inputs, step model, compare at next falling edge.
    task automatic step(input logic t, input logic c, input logic s, input logic r);
        tmr_1khz = t;
        clr      = c;
        snap_req = s;
        tx_ready = r;
        model_step(t, c, s, r);
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        tmr_1khz = 1'b0;
        clr      = 1'b0;
        snap_req = 1'b0;
        tx_ready = 1'b0;
        rst      = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_ts_i%0d", k), ts_of(k), 64'd0);
            check_eq($sformatf("rst_wrap_i%0d", k), {63'd0, wrap_o[k]}, 64'd0);
            check_eq($sformatf("rst_busy_i%0d", k), {63'd0, busy_o[k]}, 64'd0);
            check_eq($sformatf("rst_drop_i%0d", k), {63'd0, drop_o[k]}, 64'd0);
            check_eq($sformatf("rst_valid_i%0d", k), {63'd0, txv_o[k]}, 64'd0);
            check_eq($sformatf("rst_last_i%0d", k), {63'd0, txl_o[k]}, 64'd0);
            check_eq($sformatf("rst_data_i%0d", k), {56'd0, txd_o[k]}, 64'd0);
            m_ts[k]   = 0;
            m_wrap[k] = 1'b0;
            m_drop[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        rst      = 1'b1;
        tmr_1khz = 1'b0;
        clr      = 1'b0;
        snap_req = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Three ticks five cycles apart.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check_eq("t1_ts32", {32'd0, ts32}, 64'd3);
        check_eq("t1_wrap32", {63'd0, wrap_o[2]}, 64'd0);

        // 8-bit wrap, then clr beating a same-cycle tick.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (256) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t2_ts8", {56'd0, ts8}, 64'd0);
        check_eq("t2_wrap8", {63'd0, wrap_o[0]}, 64'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t2_clr_ts8", {56'd0, ts8}, 64'd0);
        check_eq("t2_clr_wrap8", {63'd0, wrap_o[0]}, 64'd0);

        // 16-bit frame of 0x0102 with tx_ready held high.
        repeat (258) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("t3_b0", {56'd0, txd_o[1]}, 64'h01);
        check_eq("t3_b0_last", {63'd0, txl_o[1]}, 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_b1", {56'd0, txd_o[1]}, 64'h02);
        check_eq("t3_b1_last", {63'd0, txl_o[1]}, 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_busy", {63'd0, busy_o[1]}, 64'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Tick coinciding with snap_req, then a stall before draining.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (255) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t4_stall0", {56'd0, txd_o[2]}, 64'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t4_stall2", {56'd0, txd_o[2]}, 64'h00);
        check_eq("t4_stall_valid", {63'd0, txv_o[2]}, 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t4_b3", {56'd0, txd_o[2]}, 64'hff);
        check_eq("t4_b3_last", {63'd0, txl_o[2]}, 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t4_busy", {63'd0, busy_o[2]}, 64'd0);
        check_eq("t4_ts32", {32'd0, ts32}, 64'h100);

        // Second request while busy is dropped; next accepted one clears the flag.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t5_drop", {63'd0, drop_o[2]}, 64'd1);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("t5_drop_clr", {63'd0, drop_o[2]}, 64'd0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while the second byte of a 4-byte frame is on the wire.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/timestamp_ms.md
Name: timestamp_ms

Overview:
Millisecond timestamp counter and serializer. It sits directly downstream of the timers block and consumes its one-cycle 1 kHz tick (tmr_1khz) to keep a free-running millisecond count. On request it snapshots the count and streams it MSB-first, one byte per valid/ready beat, to the avionics serial transmitter. This gives every telemetry frame a coherent timestamp.

Parameters:
WIDTH, 32, counter width in bits; must be a multiple of 8 and at least 8; byte count NB = WIDTH/8

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  reset; asynchronous, active-high
tmr_1khz  input  1  one-cycle tick pulse from timers; advances count by 1
clr  input  1  synchronous clear of live count and wrap flag
snap_req  input  1  one-cycle request to snapshot and transmit
ts  output  WIDTH  live millisecond count
wrap  output  1  sticky: count wrapped from all-ones to 0
busy  output  1  high while a snapshot is being transmitted
snap_drop  output  1  sticky: a snap_req was ignored while busy
tx_data  output  8  current byte of snapshot
tx_valid  output  1  tx_data valid
tx_last  output  1  high with the final (LSB) byte
tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready

Behaviour:
- Reset (async, immediate): ts=0, wrap=0, busy=0, snap_drop=0, tx_valid=0, tx_last=0, tx_data=0, shadow=0, byte index=0, FSM=IDLE.
- Counter: on tmr_1khz=1, ts <= ts+1 modulo 2^WIDTH. If ts is all-ones and a tick arrives, ts <= 0 and wrap <= 1.
- clr=1: ts <= 0 and wrap <= 0. clr beats a same-cycle tick: result is 0 and wrap is not set. clr does not touch shadow, the FSM or snap_drop.
- tmr_1khz is treated as a pulse level. It is sampled every cycle, so a tick held high for k cycles adds k.
- FSM has 2 states: IDLE and SEND.
- IDLE + snap_req=1 at edge N:
  - shadow <= ts value before any same-cycle increment, byte index <= 0, snap_drop <= 0, FSM <= SEND.
  - After edge N: busy=1, tx_valid=1, tx_data=shadow[WIDTH-1:WIDTH-8]. Latency from request to first valid byte is 1 cycle.
- SEND:
  - tx_data, tx_valid and tx_last hold stable until a beat (tx_valid && tx_ready at an edge).
  - On a non-final beat: byte index increments and the next lower byte is presented in the following cycle. There are no bubbles, so back-to-back beats are allowed.
  - tx_last=1 exactly while byte index = NB-1.
  - On the final beat: FSM <= IDLE; tx_valid, tx_last and busy go 0 the next cycle.
  - A snap_req arriving in the same cycle as the final beat is ignored and sets snap_drop.
- snap_req while busy=1: ignored and snap_drop <= 1. snap_drop stays set until the next accepted snap_req.
- The counter keeps running during SEND, so ts may diverge from the shadow. The transmitted bytes are always the coherent shadow.
- NB=1 (WIDTH=8): the first byte is also the last byte, and tx_last=1 with it.
- tx_ready is ignored while tx_valid=0.
- Reset mid-SEND: the transfer is abandoned and tx_valid drops asynchronously. No partial-frame recovery is provided.

Test Plan:
1. WIDTH=32. Reset, then 3 tmr_1khz pulses spaced 5 cycles apart -> ts=3, wrap=0. All outputs are 0 while rst=1.
2. WIDTH=8. 256 single-cycle ticks -> ts=0x00, wrap=1. Then clr together with a tick -> ts=0, wrap=0.
3. WIDTH=16, ts=0x0102, tx_ready tied 1, snap_req at cycle N -> tx_valid is high in cycles N+1..N+2 with data 0x01 then 0x02, tx_last only with 0x02, busy=0 at N+3.
4. WIDTH=32, ts=0x000000FF, a tick in the same cycle as snap_req, tx_ready low for 3 cycles and then high -> bytes are 00,00,00,FF (pre-increment value). tx_data holds 0x00 stable through the stall, and ts=0x100 afterwards.
5. Second snap_req during SEND -> snap_drop=1 and the stream is unaffected. The next accepted snap_req clears snap_drop.
6. Assert rst in the middle of byte 2 of a 4-byte send -> tx_valid=0 and busy=0 immediately. After release, a new snap_req yields a full 4-byte frame of the current ts (0 plus any ticks since).
